// File: rtl/zero_drop_pkg.sv
// Shared definitions for the zero-drop stream filter.
// Token layout: bit 16 is eos, bits 15:0 are payload.
//   eos=0                      -> data token
//   eos=1, payload[9:8]=2'b01  -> done token
//   eos=1, anything else       -> stop token (level in payload[7:0])
package zero_drop_pkg;

    localparam int         TOK_EOS_BIT = 16;
    localparam logic [1:0] TOK_STOP    = 2'b00;
    localparam logic [1:0] TOK_DONE    = 2'b01;

    typedef enum logic [1:0] {
        START = 2'd0,
        PASS  = 2'd1,
        DONE  = 2'd2
    } zd_state_t;

    function automatic logic tok_is_done(input logic [16:0] tok);
        return tok[TOK_EOS_BIT] && (tok[9:8] == TOK_DONE);
    endfunction

    // Reserved stop encodings (payload[9:8] = 2'b10/2'b11) also count as stop.
    function automatic logic tok_is_stop(input logic [16:0] tok);
        return tok[TOK_EOS_BIT] && ((tok[9:8] == TOK_STOP) || (tok[9:8] != TOK_DONE));
    endfunction

endpackage

// File: rtl/zero_drop_cr_if.sv
// Token stream bundle for zero_drop_cr.
//   data_in / data_in_valid / data_in_ready    : upstream side
//   data_out / data_out_valid / data_out_ready : downstream side
// slave  : view used by the filter itself.
// master : view used by whatever drives the filter (upstream + downstream).
interface zero_drop_cr_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH:0] data_in;
    logic                data_in_valid;
    logic                data_in_ready;
    logic [DATA_WIDTH:0] data_out;
    logic                data_out_valid;
    logic                data_out_ready;

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready,
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready,
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );
endinterface

// File: rtl/zd_sync_fifo.sv
// Synchronous FIFO used for both the input and output token queues.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pointers/count only)
//   en            : advance enable; push/pop are ignored while low
//   push, data_in : write request and word (ignored when full)
//   pop           : read request (ignored when empty)
//   data_out      : head word, reads zero while empty
//   full, empty   : occupancy flags
module zd_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = en & push & ~full;
    assign do_pop  = en & pop & ~empty;

    // Storage is not reset; the empty flag masks stale contents.
    assign data_out = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end
endmodule

// File: rtl/zero_drop_cr.sv
// Zero-drop stream filter placed ahead of the reduce/accumulate stage.
// Removes zero-valued data tokens (when drop_en=1); stop and done tokens
// always pass so fiber structure survives, including all-zero fibers.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clk_en          : global enable, all state holds when low
//   tile_en         : tile enable for the FIFOs (gclk = clk & tile_en, done
//                     here as an enable so the FSM never outruns the FIFOs)
//   drop_en         : 1 = drop zero data tokens, 0 = passthrough
//   bus             : token stream (zero_drop_cr_if.slave)
//   dropped_count   : zeros dropped since the last done token, saturating
//   stream_done     : one-cycle pulse when a done token enters the output FIFO
module zero_drop_cr
    import zero_drop_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 tile_en,
    input  logic                 drop_en,
    zero_drop_cr_if.slave        bus,
    output logic [15:0]          dropped_count,
    output logic                 stream_done
);
    localparam int TW = DATA_WIDTH + 1;

    zd_state_t       state;
    zd_state_t       next_state;
    logic            en;
    logic [TW-1:0]   head;
    logic            in_full;
    logic            in_empty;
    logic            out_full;
    logic            out_empty;
    logic            in_pop;
    logic            out_push;
    logic            drop_tok;
    logic            done_push;
    logic            hv;
    logic            head_done;
    logic            head_zero;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign en = clk_en & tile_en;

    zd_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(TW)) u_in_fifo (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .push     (bus.data_in_valid),
        .pop      (in_pop),
        .data_in  (bus.data_in),
        .data_out (head),
        .full     (in_full),
        .empty    (in_empty)
    );

    zd_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(TW)) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .push     (out_push),
        .pop      (bus.data_out_ready),
        .data_in  (head),
        .data_out (bus.data_out),
        .full     (out_full),
        .empty    (out_empty)
    );

    assign bus.data_in_ready  = ~in_full;
    assign bus.data_out_valid = ~out_empty;

    assign hv        = ~in_empty;
    assign head_done = tok_is_done(head);
    // drop_en is looked at only when the token is actually popped.
    assign head_zero = drop_en & ~head[DATA_WIDTH] & (head[DATA_WIDTH-1:0] == '0);

    always_ff @(posedge clk) begin
        if (rst)     state <= START;
        else if (en) state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_pop     = 1'b0;
        out_push   = 1'b0;
        drop_tok   = 1'b0;
        done_push  = 1'b0;
        unique case (state)
            START: begin
                if (hv) next_state = head_done ? DONE : PASS;
            end
            PASS: begin
                if (hv) begin
                    if (head_done) begin
                        next_state = DONE;
                    end else if (head_zero) begin
                        // A drop never touches the output FIFO, so it
                        // proceeds even under downstream backpressure.
                        in_pop   = 1'b1;
                        drop_tok = 1'b1;
                    end else if (!out_full) begin
                        in_pop   = 1'b1;
                        out_push = 1'b1;
                    end
                end
            end
            DONE: begin
                if (hv && !out_full) begin
                    in_pop     = 1'b1;
                    out_push   = 1'b1;
                    done_push  = 1'b1;
                    next_state = START;
                end
            end
            default: next_state = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dropped_count <= '0;
            stream_done   <= 1'b0;
        end else begin
            // The pulse must not stretch while the block is stalled.
            stream_done <= en & done_push;
            if (en) begin
                if (done_push)     dropped_count <= '0;
                else if (drop_tok) dropped_count <= sat_inc(dropped_count);
            end
        end
    end
endmodule

// File: tb/tb_zero_drop_cr.sv
module tb_zero_drop_cr;
    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        tile_en;
    logic        drop_en;
    logic [15:0] dropped_count;
    logic        stream_done;

    zero_drop_cr_if #(.DATA_WIDTH(16)) zif ();

    zero_drop_cr #(.FIFO_DEPTH(8), .DATA_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .tile_en       (tile_en),
        .drop_en       (drop_en),
        .bus           (zif.slave),
        .dropped_count (dropped_count),
        .stream_done   (stream_done)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [16:0] tx_q[$];
    logic [16:0] exp_q[$];
    int          exp_peak_q[$];
    int          zeros_cur = 0;
    int          peak = 0;
    int          vld_pct = 0;
    int          rdy_pct = 100;
    logic        rst_req = 1'b1;
    int          n_pulses = 0;
    int          n_done_out = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_done_tok(input logic [16:0] t);
        return t[16] && (t[9:8] == 2'b01);
    endfunction

    // Reference model: the filtered stream is the input stream with zero
    // data tokens removed when drop_en is set; each fiber's peak drop count
    // is the number of zeros it contained.
    task automatic enq(input logic [16:0] t);
        tx_q.push_back(t);
        if (!t[16]) begin
            if (drop_en && t[15:0] == 16'h0) zeros_cur++;
            else exp_q.push_back(t);
        end else begin
            exp_q.push_back(t);
            if (is_done_tok(t)) begin
                exp_peak_q.push_back(zeros_cur);
                zeros_cur = 0;
            end
        end
    endtask

    task automatic tick();
        logic        acc;
        logic        popped;
        logic [16:0] tok;
        logic [16:0] e;
        @(negedge clk);
        rst = rst_req;
        zif.data_in_valid  = (tx_q.size() > 0) && ($urandom_range(99) < vld_pct);
        zif.data_in        = (tx_q.size() > 0) ? tx_q[0] : 17'h0;
        zif.data_out_ready = ($urandom_range(99) < rdy_pct);
        #1;
        acc    = zif.data_in_valid & zif.data_in_ready & clk_en & tile_en & ~rst;
        popped = zif.data_out_valid & zif.data_out_ready & clk_en & tile_en & ~rst;
        tok    = zif.data_out;
        @(posedge clk);
        #1;
        if (acc) void'(tx_q.pop_front());
        if (popped) begin
            if (exp_q.size() == 0) begin
                chk("out_extra", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("out_tok", 32'(tok), 32'(e));
                if (is_done_tok(e)) n_done_out++;
            end
        end
        if (stream_done === 1'b1) begin
            n_pulses++;
            chk("cnt_clear", 32'(dropped_count), 32'd0);
            if (exp_peak_q.size() > 0) chk("peak", 32'(peak), 32'(exp_peak_q.pop_front()));
            else chk("pulse_extra", 32'(exp_peak_q.size()), 32'd1);
            peak = 0;
        end else if (int'(dropped_count) > peak) begin
            peak = int'(dropped_count);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((tx_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain", 32'(tx_q.size() + exp_q.size()), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        clk_en  = 1'b1;
        tile_en = 1'b1;
        drop_en = 1'b1;
        zif.data_in        = 17'h0;
        zif.data_in_valid  = 1'b0;
        zif.data_out_ready = 1'b0;

        // Reset state
        rst_req = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(zif.data_out_valid), 32'd0);
        chk("rst_in_ready", 32'(zif.data_in_ready), 32'd1);
        chk("rst_data_out", 32'(zif.data_out), 32'd0);
        chk("rst_count", 32'(dropped_count), 32'd0);
        chk("rst_done", 32'(stream_done), 32'd0);
        rst_req = 1'b0;
        tick();

        // D5 D0 D7 S0 done with dropping
        drop_en = 1'b1; vld_pct = 100; rdy_pct = 100;
        enq(17'h00005); enq(17'h00000); enq(17'h00007); enq(17'h10000); enq(17'h10100);
        tick();
        chk("latency", 32'(zif.data_out_valid), 32'd0);
        drain(200);

        // All-zero fiber keeps its stop token
        enq(17'h00000); enq(17'h00000); enq(17'h10000); enq(17'h10100);
        drain(200);

        // Passthrough
        drop_en = 1'b0;
        enq(17'h00000); enq(17'h00003); enq(17'h10001); enq(17'h10100);
        drain(200);

        // Backpressure: both FIFOs fill, then everything drains in order
        drop_en = 1'b1; vld_pct = 100; rdy_pct = 0;
        for (int i = 0; i < 20; i++) enq(17'(i + 1));
        enq(17'h10000); enq(17'h10100);
        repeat (40) tick();
        chk("bp_in_ready", 32'(zif.data_in_ready), 32'd0);
        chk("bp_out_valid", 32'(zif.data_out_valid), 32'd1);
        chk("bp_accepted", 32'(22 - tx_q.size()), 32'd16);
        rdy_pct = 100;
        drain(400);

        // Reset mid-stream
        vld_pct = 100; rdy_pct = 100;
        enq(17'h00004);
        tick();
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        tx_q.delete(); exp_q.delete(); exp_peak_q.delete();
        zeros_cur = 0; peak = 0;
        chk("mrst_out_valid", 32'(zif.data_out_valid), 32'd0);
        chk("mrst_in_ready", 32'(zif.data_in_ready), 32'd1);
        chk("mrst_count", 32'(dropped_count), 32'd0);
        chk("mrst_data_out", 32'(zif.data_out), 32'd0);
        enq(17'h00009); enq(17'h10000); enq(17'h10100);
        drain(200);

        // clk_en low while in DONE
        enq(17'h10100);
        tick();
        tick();
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ce_hold_valid", 32'(zif.data_out_valid), 32'd0);
            chk("ce_hold_done", 32'(stream_done), 32'd0);
        end
        clk_en = 1'b1;
        tick();
        chk("ce_resume_valid", 32'(zif.data_out_valid), 32'd1);
        chk("ce_resume_done", 32'(stream_done), 32'd1);
        drain(200);

        // Randomized fibers
        for (int s = 0; s < 30; s++) begin
            int          n;
            int          r;
            int          sel;
            logic [15:0] p;
            drop_en = 1'($urandom_range(1));
            vld_pct = int'($urandom_range(100, 30));
            rdy_pct = int'($urandom_range(100, 30));
            n = int'($urandom_range(10));
            for (int k = 0; k < n; k++) begin
                r = int'($urandom_range(9));
                p = 16'($urandom_range(65535));
                if (r < 4) begin
                    enq(17'h00000);
                end else if (r < 8) begin
                    enq({1'b0, p});
                end else begin
                    sel = int'($urandom_range(2));
                    p[9:8] = (sel == 0) ? 2'b00 : ((sel == 1) ? 2'b10 : 2'b11);
                    enq({1'b1, p});
                end
            end
            p = 16'($urandom_range(65535));
            p[9:8] = 2'b01;
            enq({1'b1, p});
            drain(2000);
        end

        chk("pulses", 32'(n_pulses), 32'(n_done_out));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
